mux_tree_pipe: RTL
==================

// Module: mux_tree_pipe
// PURPOSE
//   Parametrised, pipelined N:1 multiplexer tree with a valid/ready handshake.
//   It generalises the fixed 4:1 two-level 1-bit mux tree to any width and input count.
//   Each tree level is a registered stage, so arbitrarily deep trees close timing.
//   It sits between a bank of same-width sources and a single consumer.
//   The consumer may stall; backpressure propagates to the source.
// PARAMETERS
//   WIDTH     8  bits per data input and per output
//   N_INPUTS  8  number of data inputs (>=2; need not be a power of two)
//   SEL_W     $clog2(N_INPUTS)  select width (derived, do not override)
//   LEVELS    SEL_W  tree depth = pipeline latency in cycles (derived)
// PORTS
//   clk        in   1                 rising-edge clock
//   rst_n      in   1                 asynchronous active-low reset
//   in_data    in   N_INPUTS*WIDTH    packed inputs; input i = in_data[i*WIDTH +: WIDTH]
//   in_sel     in   SEL_W             index of the input to forward
//   in_valid   in   1                 in_data/in_sel are valid this cycle
//   in_ready   out  1                 tree accepts a beat this cycle
//   out_data   out  WIDTH             selected data
//   out_sel_err out 1                 beat carried in_sel >= N_INPUTS
//   out_valid  out  1                 out_data/out_sel_err are valid
//   out_ready  in   1                 consumer accepts a beat
// BEHAVIOUR
//   - Reset (rst_n low, async assert, sync-release via flops):
//     - every stage valid = 0, so out_valid = 0;
//     - out_data = 0 and out_sel_err = 0.
//     - Reset mid-operation discards all in-flight beats.
//     - No beat is emitted after release until new input is accepted.
//   - Stage k (k = 0..LEVELS-1) holds:
//     - ceil(N_INPUTS / 2^(k+1)) partial results, each WIDTH bits;
//     - the unconsumed select bits [SEL_W-1:k+1];
//     - a valid bit and the err flag.
//   - Level k picks pairs using select bit k (LSB first):
//     - node j = sel[k] ? node(2j+1) : node(2j);
//     - an odd last node with no partner passes through when sel[k]=0;
//     - with sel[k]=1 it yields 0 and sets err.
//   - err = (in_sel >= N_INPUTS); data for an erroneous beat is forced to 0.
//   - Handshake, per stage:
//     - adv_LEVELS = out_ready;
//     - adv_k = !valid_k || adv_(k+1);
//     - in_ready = adv_0 (combinational from out_ready; no reg on ready path).
//     - Stage k loads from stage k-1 (stage 0 from inputs) when adv_k.
//     - On load, valid_k = valid of the source; otherwise the stage holds.
//   - Beat transfer rules:
//     - a beat enters on in_valid && in_ready;
//     - it leaves on out_valid && out_ready.
//   - Latency is exactly LEVELS cycles with out_ready held high.
//   - Throughput is 1 beat/cycle.
//   - Stalls:
//     - out_data/out_sel_err are stable while out_valid && !out_ready.
//     - Bubbles are squeezed: an empty stage accepts even when downstream stalls.
//   - in_data/in_sel are don't-care when in_valid = 0.
//     - Stage data regs may still load, but valid stays 0.
//   - The tree holds at most LEVELS beats in flight.
//     - Order is preserved; no beat is dropped or duplicated.
//   - N_INPUTS = 2 degenerates to one registered 2:1 stage (latency 1).
// TESTING
//   - Reset: hold rst_n=0 with in_valid=1. Expect out_valid=0, out_data=0, in_ready=1.
//     Release, then drive no input. Expect out_valid to stay 0.
//   - Sweep (WIDTH=8, N=8): in_data[i]=8'h10+i, sel=0..7 back-to-back, out_ready=1.
//     Expect out_data 8'h10..8'h17 in order, first beat 3 cycles after the first accept.
//   - Stall: out_ready=0 for 5 cycles mid-stream. Expect in_ready=0 once 3 beats are held.
//     Expect out_data frozen during the stall. Expect no loss or duplication after release.
//   - Bubble squeeze: issue one beat, idle 2 cycles, then out_ready=0.
//     Expect 2 further beats accepted before in_ready drops.
//   - Out of range (N=5, WIDTH=4): sel=5 -> out_data=0, out_sel_err=1.
//     sel=4 -> in_data[4], err=0.
//   - Reset mid-flight: assert rst_n low with 3 beats queued.
//     Expect out_valid to fall immediately (async). After release, expect no stale beat.

Source files
------------

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined N:1 mux tree, one register stage per
// select bit, valid/ready handshake with bubble squeeze.
module mux_tree_pipe #(
  parameter int WIDTH    = 8,
  parameter int N_INPUTS = 8,
  parameter int SEL_W    = $clog2(N_INPUTS),
  parameter int LEVELS   = SEL_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_INPUTS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_sel_err,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int HALF = (N_INPUTS + 1) / 2;
  localparam int HW   = HALF * WIDTH;
  localparam int SW   = 2 * HW;

  // One tree level: pair nodes on select bit b; a lone last
  // node survives only on b=0, otherwise the result is zero.
  function automatic logic [HW-1:0] pick(
    input logic [SW-1:0] s,
    input logic          b,
    input int            ni
  );
    logic [HW-1:0] r;
    r = '0;
    for (int j = 0; j < HALF; j++) begin
      if (!b && (2 * j < ni))
        r[j*WIDTH +: WIDTH] = s[2*j*WIDTH +: WIDTH];
      else if (b && (2 * j + 1 < ni))
        r[j*WIDTH +: WIDTH] = s[(2*j+1)*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  logic [LEVELS-1:0] vld;
  logic [LEVELS-1:0] err;
  logic [LEVELS-1:0] s_vld;
  logic [LEVELS-1:0] s_err;
  logic [LEVELS:0]   adv;
  logic [SEL_W-1:0]  sel   [LEVELS];
  logic [SEL_W-1:0]  s_sel [LEVELS];
  logic [HW-1:0]     dat   [LEVELS];
  logic [HW-1:0]     nxt   [LEVELS];
  logic [SW-1:0]     src   [LEVELS];
  logic              bad;

  assign bad = {1'b0, in_sel} >= (SEL_W+1)'(N_INPUTS);

  // Advance chain: a stage may load if empty or its
  // successor advances; the tail follows out_ready.
  always_comb begin
    adv[LEVELS] = out_ready;
    for (int k = LEVELS - 1; k >= 0; k--)
      adv[k] = !vld[k] || adv[k+1];
  end

  // Source of each stage: inputs for stage 0, else
  // the previous stage's registers.
  always_comb begin
    s_vld[0] = in_valid;
    s_err[0] = bad;
    s_sel[0] = in_sel;
    src[0]   = SW'(in_data);
    for (int k = 1; k < LEVELS; k++) begin
      s_vld[k] = vld[k-1];
      s_err[k] = err[k-1];
      s_sel[k] = sel[k-1];
      src[k]   = SW'(dat[k-1]);
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int NI = (N_INPUTS + (1 << k) - 1) >> k;
    assign nxt[k] = pick(src[k], s_sel[k][0], NI);
  end

  // Stage registers: load on advance, else hold;
  // the consumed select bit is shifted out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      err <= '0;
      for (int k = 0; k < LEVELS; k++) begin
        sel[k] <= '0;
        dat[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LEVELS; k++) begin
        if (adv[k]) begin
          vld[k] <= s_vld[k];
          err[k] <= s_err[k];
          sel[k] <= s_sel[k] >> 1;
          dat[k] <= nxt[k];
        end
      end
    end
  end

  assign in_ready    = adv[0];
  assign out_valid   = vld[LEVELS-1];
  assign out_sel_err = err[LEVELS-1];
  assign out_data    = dat[LEVELS-1][WIDTH-1:0];

endmodule
